// File: rtl/scroll_sequencer.sv
// scroll_sequencer: owns a SIZE x WIDTH circular pattern buffer. A pattern is
// loaded from a byte stream, then rotated one entry per prescaler period in
// the selected direction. Each shift and each completed frame is flagged.
//
// Handshake: a byte transfers on a rising clk edge where in_valid and
// in_ready are both high. in_ready is a registered output that is high for
// exactly the cycles the FSM is in LOAD and does not depend on in_valid.
// A load_start seen in the same cycle as a transfer discards that byte.
module scroll_sequencer #(
  parameter int WIDTH = 8,
  parameter int SIZE  = 16,
  parameter int DIV_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_start,
  input  logic [WIDTH-1:0]        in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    run_en,
  input  logic                    dir,
  input  logic [DIV_W-1:0]        step_div,
  output logic [SIZE*WIDTH-1:0]   reg_out,
  output logic                    shift_pulse,
  output logic                    frame_done,
  output logic [1:0]              state
);

  localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(SIZE - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [DIV_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [IDX_W-1:0]       rot_q, rot_d;
  logic [SIZE*WIDTH-1:0]  pat_q;
  logic [SIZE*WIDTH-1:0]  pat_up, pat_dn;
  logic                   in_ready_q;
  logic                   do_shift;
  logic                   wr_en;

  // Rotated views of the buffer: up moves entry i to i+1, down moves i to i-1.
  assign pat_up = {pat_q[(SIZE-1)*WIDTH-1:0], pat_q[SIZE*WIDTH-1 -: WIDTH]};
  assign pat_dn = {pat_q[WIDTH-1:0], pat_q[SIZE*WIDTH-1:WIDTH]};

  // Next-state, prescaler, load index and rotation count.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    rot_d    = rot_q;
    do_shift = 1'b0;
    wr_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          idx_d   = '0;
          rot_d   = '0;
        end else if (run_en) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (load_start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          idx_d   = '0;
          rot_d   = '0;
        end else if (!run_en) begin
          // Rotation count survives a pause so the frame resumes.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == step_div) begin
          do_shift = 1'b1;
          cnt_d    = '0;
          rot_d    = (rot_q == LAST) ? '0 : rot_q + IDX_W'(1);
        end else begin
          // A live reduction of step_div below cnt_q wraps through 2^DIV_W.
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      ST_LOAD: begin
        if (load_start) begin
          idx_d = '0;
          rot_d = '0;
        end else if (in_valid && in_ready_q) begin
          wr_en = 1'b1;
          if (idx_q == LAST) begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      rot_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rot_q   <= rot_d;
    end
  end

  // Pattern buffer: load writes one entry, a shift rotates the whole buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q <= '0;
    end else if (wr_en) begin
      pat_q[idx_q*WIDTH +: WIDTH] <= in_data;
    end else if (do_shift) begin
      pat_q <= dir ? pat_dn : pat_up;
    end
  end

  // Registered status: pulses line up with the shifted contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_q  <= 1'b0;
      shift_pulse <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      in_ready_q  <= (state_d == ST_LOAD);
      shift_pulse <= do_shift;
      frame_done  <= do_shift && (rot_q == LAST);
    end
  end

  assign in_ready = in_ready_q;
  assign reg_out  = pat_q;
  assign state    = state_q;

endmodule

// File: tb/tb_scroll_sequencer.sv
// Directed bench for scroll_sequencer: a vector table for the load stream,
// then hand-written sequences for rotation, pause, interrupted load and reset.
module tb_scroll_sequencer;

  localparam int W = 8;
  localparam int S = 16;
  localparam int D = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           load_start;
  logic [W-1:0]   in_data;
  logic           in_valid;
  logic           in_ready;
  logic           run_en;
  logic           dir;
  logic [D-1:0]   step_div;
  logic [S*W-1:0] reg_out;
  logic           shift_pulse;
  logic           frame_done;
  logic [1:0]     state;

  scroll_sequencer #(.WIDTH(W), .SIZE(S), .DIV_W(D)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .run_en(run_en), .dir(dir),
    .step_div(step_div), .reg_out(reg_out), .shift_pulse(shift_pulse),
    .frame_done(frame_done), .state(state)
  );

  // Clock
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected pattern model: pat holds the last loaded contents, rot_r the net
  // rotation (+1 per up shift, -1 per down shift), tot the shifts since load.
  logic [W-1:0] pat [S];
  logic [W-1:0] cur [S];
  int rot_r;
  int tot;

  typedef struct {
    logic       ls;
    logic       iv;
    logic [7:0] d;
    logic [1:0] e_state;
    logic       e_rdy;
  } vec_t;
  vec_t tbl [20];

  task automatic chk(input string nm, input logic [S*W-1:0] act, input logic [S*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [S*W-1:0] pack_cur();
    logic [S*W-1:0] v;
    v = '0;
    for (int i = 0; i < S; i++) v[i*W +: W] = cur[i];
    return v;
  endfunction

  function automatic logic [S*W-1:0] rot_exp(input int r);
    logic [S*W-1:0] v;
    int k;
    v = '0;
    for (int i = 0; i < S; i++) begin
      k = ((i - r) % S + S) % S;
      v[i*W +: W] = pat[k];
    end
    return v;
  endfunction

  // Wait (bounded) for the next shift_pulse; frame_done must stay low meanwhile.
  task automatic wait_pulse(input string nm, output int gap);
    gap = 0;
    do begin
      step();
      gap++;
      if (!shift_pulse) chk({nm, "_frame_idle"}, S*W'(frame_done), '0);
    end while (!shift_pulse && gap < 40);
    if (!shift_pulse) chk({nm, "_timeout"}, '0, S*W'(1));
  endtask

  task automatic run_shifts(input string nm, input int n, input int dstep,
                            input int first_gap, input int gap_exp);
    int gap;
    for (int k = 1; k <= n; k++) begin
      wait_pulse(nm, gap);
      if (k == 1) chk({nm, "_first_gap"}, S*W'(gap), S*W'(first_gap));
      else        chk({nm, "_gap"}, S*W'(gap), S*W'(gap_exp));
      rot_r += dstep;
      tot++;
      chk({nm, "_frame"}, S*W'(frame_done), S*W'((tot % S) == 0));
      chk({nm, "_data"}, reg_out, rot_exp(rot_r));
    end
  endtask

  initial begin
    rst = 1'b1; load_start = 1'b0; in_data = '0; in_valid = 1'b0;
    run_en = 1'b0; dir = 1'b0; step_div = '0;

    // Reset: three cycles held, then ten quiet cycles.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_reg_out", reg_out, '0);
    chk("rst_state", S*W'(state), '0);
    chk("rst_in_ready", S*W'(in_ready), '0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_shift", S*W'(shift_pulse), '0);
      chk("idle_frame", S*W'(frame_done), '0);
    end

    // Load table: start, bytes 0..4, two idle beats, bytes 5..15, one idle.
    tbl[0] = '{ls: 1'b1, iv: 1'b0, d: 8'h00, e_state: 2'd2, e_rdy: 1'b1};
    for (int b = 0; b < 16; b++) begin
      int r;
      r = (b < 5) ? b + 1 : b + 3;
      tbl[r] = '{ls: 1'b0, iv: 1'b1, d: 8'(b),
                 e_state: (b == 15) ? 2'd0 : 2'd2, e_rdy: (b != 15)};
    end
    tbl[6]  = '{ls: 1'b0, iv: 1'b0, d: 8'h55, e_state: 2'd2, e_rdy: 1'b1};
    tbl[7]  = '{ls: 1'b0, iv: 1'b0, d: 8'h66, e_state: 2'd2, e_rdy: 1'b1};
    tbl[19] = '{ls: 1'b0, iv: 1'b1, d: 8'h77, e_state: 2'd0, e_rdy: 1'b0};
    for (int r = 0; r < 20; r++) begin
      load_start = tbl[r].ls;
      in_valid   = tbl[r].iv;
      in_data    = tbl[r].d;
      step();
      chk($sformatf("tbl%0d_state", r), S*W'(state), S*W'(tbl[r].e_state));
      chk($sformatf("tbl%0d_rdy", r), S*W'(in_ready), S*W'(tbl[r].e_rdy));
      chk($sformatf("tbl%0d_shift", r), S*W'(shift_pulse), '0);
    end
    load_start = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < S; i++) pat[i] = 8'(i);
    rot_r = 0; tot = 0;
    chk("load_data", reg_out, rot_exp(0));

    // Rotate up, step_div=3: first shift five edges after enabling, then every 4.
    dir = 1'b0; step_div = 16'd3; run_en = 1'b1;
    run_shifts("up", 16, 1, 5, 4);
    chk("up_wrapped", reg_out, rot_exp(0));
    run_en = 1'b0;
    step();
    chk("up_stop_state", S*W'(state), '0);

    // Rotate down every cycle, paused after five shifts.
    dir = 1'b1; step_div = 16'd0; run_en = 1'b1;
    run_shifts("dn_a", 5, -1, 2, 1);
    run_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("pause_shift", S*W'(shift_pulse), '0);
      chk("pause_state", S*W'(state), '0);
    end
    chk("pause_data", reg_out, rot_exp(rot_r));
    run_en = 1'b1;
    run_shifts("dn_b", 11, -1, 2, 1);
    run_shifts("dn_c", 3, -1, 1, 1);

    // Interrupted load: load_start exactly where a shift would fire (count 2).
    step_div = 16'd2;
    step();
    chk("pre_ld_shift1", S*W'(shift_pulse), '0);
    step();
    chk("pre_ld_shift2", S*W'(shift_pulse), '0);
    load_start = 1'b1;
    step();
    load_start = 1'b0; run_en = 1'b0;
    chk("int_state", S*W'(state), S*W'(2));
    chk("int_shift", S*W'(shift_pulse), '0);
    chk("int_rdy", S*W'(in_ready), S*W'(1));
    chk("int_data", reg_out, rot_exp(rot_r));
    for (int i = 0; i < S; i++) cur[i] = pat[((i - rot_r) % S + S) % S];
    for (int b = 0; b < 5; b++) begin
      in_valid = 1'b1; in_data = 8'hA0 + 8'(b);
      step();
      cur[b] = 8'hA0 + 8'(b);
    end
    // Restart together with a valid byte: byte dropped, earlier entries kept.
    load_start = 1'b1; in_data = 8'hEE;
    step();
    load_start = 1'b0;
    chk("restart_state", S*W'(state), S*W'(2));
    chk("restart_rdy", S*W'(in_ready), S*W'(1));
    chk("partial_data", reg_out, pack_cur());
    for (int b = 0; b < 16; b++) begin
      in_data = 8'hB0 + 8'(b);
      step();
      chk($sformatf("b%0d_state", b), S*W'(state), (b == 15) ? '0 : S*W'(2));
    end
    in_valid = 1'b0;
    chk("b_rdy", S*W'(in_ready), '0);
    for (int i = 0; i < S; i++) pat[i] = 8'hB0 + 8'(i);
    rot_r = 0; tot = 0;
    chk("b_data", reg_out, rot_exp(0));
    // Rotation count was 3 before the load; a full frame of 16 proves it cleared.
    dir = 1'b0; step_div = 16'd0; run_en = 1'b1;
    run_shifts("b_up", 16, 1, 2, 1);
    run_en = 1'b0;
    step();

    // Mid-load reset after 7 bytes: asynchronous clear within the cycle.
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int b = 0; b < 7; b++) begin
      in_valid = 1'b1; in_data = 8'hC0 + 8'(b);
      step();
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_data", reg_out, '0);
    chk("arst_state", S*W'(state), '0);
    chk("arst_rdy", S*W'(in_ready), '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("post_rst_shift", S*W'(shift_pulse), '0);
    end
    for (int i = 0; i < S; i++) pat[i] = '0;
    rot_r = 0; tot = 0;
    run_en = 1'b1;
    run_shifts("post_rst", 1, 1, 2, 1);
    run_en = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
